// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one combinational ADD/SUB/DIV datapath between two requesters.
// Operands are held in registers for the execute window; results return over a rsp handshake.
module alu_scheduler #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op_select,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] OneLoad = CntW'(1);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpDiv = 2'b10;
  localparam logic [1:0] OpIll = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  logic             any_valid;
  logic             grant_id;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_err;
  logic             accept;
  logic             exec_done;

  // Arbitration: with both valid, favour the requester not served last.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_q;
    end else begin
      grant_id = ~req0_valid;
    end
    sel_op  = grant_id ? req1_opcode : req0_opcode;
    sel_a   = grant_id ? req1_a      : req0_a;
    sel_b   = grant_id ? req1_b      : req0_b;
    sel_err = (sel_op == OpIll) || ((sel_op == OpDiv) && (sel_b == '0));
    accept    = (state_q == StIdle) && any_valid;
    exec_done = (cnt_q <= OneLoad);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = sel_err ? StResp : StExec;
        end
      end
      StExec: begin
        if (exec_done) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    id_d   = id_q;
    data_d = data_q;
    err_d  = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d  = sel_op;
          a_d   = sel_a;
          b_d   = sel_b;
          id_d  = grant_id;
          cnt_d = (sel_op == OpDiv) ? DivLoad : OneLoad;
          if (sel_err) begin
            data_d = '0;
            err_d  = 1'b1;
          end
        end
      end
      StExec: begin
        cnt_d = cnt_q - OneLoad;
        if (exec_done) begin
          data_d = alu_result;
          err_d  = 1'b0;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          last_d = id_q;
        end
      end
      default: ;
    endcase
  end

  // Reset leaves last_q = 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      last_q <= 1'b1;
      op_q   <= OpAdd;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      id_q   <= id_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    rsp_valid     = 1'b0;
    unique case (state_q)
      StIdle: begin
        req0_ready = any_valid & ~grant_id;
        req1_ready = any_valid &  grant_id;
      end
      StResp:  rsp_valid = 1'b1;
      default: ;
    endcase
    rsp_id        = id_q;
    rsp_data      = data_q;
    rsp_err       = err_q;
    alu_a         = a_q;
    alu_b         = b_q;
    alu_op_select = op_q;
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst)
    !(req0_ready && req1_ready));

  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst)
    (rsp_valid && !rsp_ready) |=>
      (rsp_valid && $stable(rsp_data) && $stable(rsp_id) && $stable(rsp_err)));

  a_no_accept_busy: assert property (@(posedge clk) disable iff (!rst)
    (state_q != StIdle) |-> !(req0_ready || req1_ready));

  // OpSub is named for readability of the opcode map only.
  logic unused_opsub;
  assign unused_opsub = ^OpSub;

endmodule
